uart_frame_arbiter: RTL

Shares the single RS-232 byte transmitter between up to 16 requesters (e.g. TDC channels), turning each granted request into a framed packet. Packet layout: sync byte, channel ID, payload MSB-first, XOR checksum. Sits between the TDC capture logic and the transmitter's start/data/busy interface. Requesters are granted round-robin, and every transmitter handshake is checked against a start-acknowledge timeout.

---
 rtl/uart_frame_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that frames each granted requester payload as
// SYNC, ID, payload (MSB first), XOR checksum onto a shared byte transmitter.
module uart_frame_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned NBYTES      = 4,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*NBYTES*8-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [3:0]               grant_id,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     tx_err
);
  localparam int unsigned PW = NBYTES * 8;
  localparam int unsigned IW = $clog2(NBYTES + 3);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 2);
  localparam logic [CW-1:0] TIMEOUT  = CW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} arbState;

  arbState       state, stateNxt;
  logic [3:0]    rr, rrNxt;
  logic [PW-1:0] shiftReg, shiftNxt;
  logic [7:0]    chk, chkNxt;
  logic [IW-1:0] byteIdx, idxNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic [NREQ-1:0] readyNxt;
  logic          startNxt, busyNxt, doneNxt, errNxt;
  logic [7:0]    txDataNxt;
  logic [3:0]    grantNxt;

  logic          anyReq;
  logic [3:0]    winner;
  int unsigned   cand;
  logic [PW-1:0] winPayload;
  logic [7:0]    curByte;
  logic [CW-1:0] cntInc;

  // First requesting index at or after rr, wrapping modulo NREQ
  always_comb begin
    anyReq = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr) + k) % NREQ;
      if (!anyReq && ((req_valid >> cand) & NREQ'(1)) != '0) begin
        anyReq = 1'b1;
        winner = 4'(cand);
      end
    end
  end

  assign winPayload = PW'(req_data >> (32'(winner) * PW));
  assign cntInc     = cnt + CW'(1);

  always_comb begin
    if (byteIdx == '0)            curByte = SYNC_BYTE;
    else if (byteIdx == IW'(1))   curByte = {4'h0, grant_id};
    else if (byteIdx == LAST_IDX) curByte = chk;
    else                          curByte = shiftReg[PW-1 -: 8];
  end

  always_comb begin
    stateNxt  = state;
    rrNxt     = rr;
    shiftNxt  = shiftReg;
    chkNxt    = chk;
    idxNxt    = byteIdx;
    cntNxt    = cnt;
    readyNxt  = '0;
    startNxt  = 1'b0;
    txDataNxt = tx_data;
    grantNxt  = grant_id;
    busyNxt   = frame_busy;
    doneNxt   = 1'b0;
    errNxt    = 1'b0;
    unique case (state)
      IDLE: begin
        busyNxt = 1'b0;
        if (anyReq) begin
          shiftNxt = winPayload;
          grantNxt = winner;
          readyNxt = NREQ'(1) << winner;
          chkNxt   = '0;
          idxNxt   = '0;
          rrNxt    = (32'(winner) + 1 == NREQ) ? 4'd0 : 4'(32'(winner) + 1);
          busyNxt  = 1'b1;
          stateNxt = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          txDataNxt = curByte;
          startNxt  = 1'b1;
          cntNxt    = '0;
          stateNxt  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          stateNxt = WAIT_LO;
        end else begin
          cntNxt = cntInc;
          // Transmitter never acknowledged: drop the whole frame
          if (cntInc == TIMEOUT) begin
            errNxt   = 1'b1;
            busyNxt  = 1'b0;
            stateNxt = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (byteIdx == LAST_IDX) begin
            doneNxt  = 1'b1;
            busyNxt  = 1'b0;
            stateNxt = IDLE;
          end else begin
            idxNxt = byteIdx + IW'(1);
            if (byteIdx != '0) chkNxt = chk ^ tx_data;
            if (byteIdx > IW'(1)) shiftNxt = shiftReg << 8;
            stateNxt = SEND;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr         <= '0;
      shiftReg   <= '0;
      chk        <= '0;
      byteIdx    <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= stateNxt;
      rr         <= rrNxt;
      shiftReg   <= shiftNxt;
      chk        <= chkNxt;
      byteIdx    <= idxNxt;
      cnt        <= cntNxt;
      req_ready  <= readyNxt;
      tx_start   <= startNxt;
      tx_data    <= txDataNxt;
      grant_id   <= grantNxt;
      frame_busy <= busyNxt;
      frame_done <= doneNxt;
      tx_err     <= errNxt;
    end
  end

endmodule
